ld_ctrl_backend: RTL and testbench
==================================

# ld_ctrl_backend

Back-end load controller for the CRAM load path, directly downstream of the load front-end controller. Once the front-end has captured length, stride and base and raised its start-load flag, this block generates the strided address sequence and issues synchronous reads to the CRAM array. It returns data through a 2-entry stall-tolerant output buffer, and reports completion back to the front-end through terminate and ack pulses.

## Interface
- WIDTH_ADDR, 10, CRAM word-address width
- WIDTH_DATA, 32, data word width
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- I_Start_Load  input  1  start request from front-end; sampled only in IDLE
- I_Indirect  input  1  indirect-access mode flag; captured with I_Start_Load
- I_Length  input  WIDTH_ADDR+1  number of words to read; captured with I_Start_Load
- I_Stride  input  WIDTH_ADDR  address increment; captured
- I_Base  input  WIDTH_ADDR  first address; captured
- I_Stall  input  1  downstream stall; a word is transferred when O_Valid & ~I_Stall
- I_Rd_Data  input  WIDTH_DATA  CRAM read data, valid exactly 1 cycle after O_Rd_Req
- O_Rd_Req  output  1  CRAM read strobe
- O_Rd_Addr  output  WIDTH_ADDR  CRAM read address
- O_Valid  output  1  output buffer non-empty
- O_Data  output  WIDTH_DATA  buffer head word
- O_Last  output  1  head word is the final word of the sequence
- O_Term_Load  output  1  one-cycle end-of-load pulse (front-end is_Term_Load)
- O_Ack  output  1  one-cycle ack pulse, indirect mode only (front-end is_Ack_BackEnd)
- O_Error  output  1  one-cycle bound-violation pulse; tied 0 without the macro
- O_Busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - On I_Start_Load, capture base, stride, length and indirect flag.
  - Length 0 goes to DONE with no reads; otherwise go to LOAD.
- LOAD:
  - Issue a read when credit is available: (buffer count + in-flight − pop) < 2, where pop = O_Valid & ~I_Stall.
  - Each issue: O_Rd_Addr = current address; then address += stride (mod 2^WIDTH_ADDR) and remaining −= 1.
  - After the issue that takes remaining to 0, go to DRAIN.
- DRAIN: wait until the buffer is empty and no read is in flight, then go to DONE.
- DONE: pulse O_Term_Load for 1 cycle; pulse O_Ack in the same cycle if captured indirect = 1; go to IDLE.
- Returning data is written into the buffer the cycle after the request. Credit accounting guarantees the buffer never overflows.
- O_Last is tagged on the word whose read was issued with remaining = 1.
- I_Start_Load outside IDLE is ignored. I_Length/I_Stride/I_Base changes after capture are ignored.
- Simultaneous push and pop on a full buffer is legal: count is unchanged, order is preserved (FIFO).

## Timing
- Reset values (asynchronous): state IDLE; O_Rd_Req, O_Valid, O_Last, O_Term_Load, O_Ack, O_Error, O_Busy = 0; O_Rd_Addr = 0; O_Data = 0; buffer empty; in-flight cleared.
- Reset asserted mid-sequence aborts immediately. Read data returning after reset release is discarded.
- Start sampled at cycle 0 → first O_Rd_Req at cycle 1 → first O_Valid at cycle 2.
- With no stall, throughput is 1 word/cycle. For an N-word load:
  - last word at cycle N+1;
  - DRAIN is reached after the final issue;
  - O_Term_Load occurs at cycle N+3 (DRAIN exits the cycle after the final pop);
  - O_Busy deasserts at cycle N+4.
- While I_Stall = 1: O_Data and O_Valid are held, at most 2 words are buffered, and issue pauses.
- O_Rd_Req may be high on consecutive cycles. O_Rd_Addr is meaningful only when O_Rd_Req = 1.

## Configuration
- Macro: LD_BACKEND_BOUND_CHK_EN.
- Defined:
  - If base + k·stride would exceed 2^WIDTH_ADDR−1 before remaining reaches 0, the offending read is not issued.
  - The preceding word becomes O_Last; O_Error pulses together with O_Term_Load in DONE.
- Undefined: addresses wrap modulo 2^WIDTH_ADDR and O_Error is constant 0.

## Test plan
- Base 0x010, stride 1, length 4, no stall → reads 0x010..0x013 at cycles 1–4; O_Valid cycles 2–5; O_Last at cycle 5; O_Term_Load at cycle 7; O_Ack = 0.
- Base 0x000, stride 3, length 5, I_Stall high cycles 3–6 → addresses 0,3,6,9,12; no word lost or duplicated; never more than 2 outstanding plus buffered; data order preserved.
- Length 0, indirect = 1 → no O_Rd_Req; O_Term_Load and O_Ack pulse together at cycle 1; IDLE at cycle 2.
- Base 0x3FE, stride 1, length 4, WIDTH_ADDR 10:
  - with the macro undefined, addresses 0x3FE, 0x3FF, 0x000, 0x001;
  - with LD_BACKEND_BOUND_CHK_EN defined, only 0x3FE and 0x3FF are read, O_Last is on the second word, and O_Error pulses with O_Term_Load.
- Reset asserted at cycle 3 of a 6-word load → all outputs 0 immediately; the first read after restart starts at the new base; no stale data appears.
- I_Start_Load re-pulsed during LOAD with different base → ignored; the original sequence completes unchanged.

Source files
------------

// File: rtl/ld_ctrl_backend.sv
// Back-end load controller: strided CRAM read sequencer feeding a 2-entry bypass output buffer.
// Optional macro LD_BACKEND_BOUND_CHK_EN stops the sequence at the end of the address space and flags O_Error.
module ld_ctrl_backend #(
    parameter int WIDTH_ADDR = 10,
    parameter int WIDTH_DATA = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Start_Load,
    input  logic                  I_Indirect,
    input  logic [WIDTH_ADDR:0]   I_Length,
    input  logic [WIDTH_ADDR-1:0] I_Stride,
    input  logic [WIDTH_ADDR-1:0] I_Base,
    input  logic                  I_Stall,
    input  logic [WIDTH_DATA-1:0] I_Rd_Data,
    output logic                  O_Rd_Req,
    output logic [WIDTH_ADDR-1:0] O_Rd_Addr,
    output logic                  O_Valid,
    output logic [WIDTH_DATA-1:0] O_Data,
    output logic                  O_Last,
    output logic                  O_Term_Load,
    output logic                  O_Ack,
    output logic                  O_Error,
    output logic                  O_Busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t                       r_state;
    logic [WIDTH_ADDR-1:0]        r_addr;
    logic [WIDTH_ADDR-1:0]        r_stride;
    logic [WIDTH_ADDR:0]          r_rem;
    logic                         r_indirect;
    logic                         r_req_last;
    logic                         r_arr;
    logic                         r_arr_last;
    logic [1:0]                   r_cnt;
    logic [1:0][WIDTH_DATA:0]     r_buf;

    logic [WIDTH_ADDR-1:0]        w_addr_nxt;
    logic                         w_ovf;
    logic                         w_last;
    logic                         w_pop;
    logic [2:0]                   w_occ;
    logic                         w_credit;
    logic [WIDTH_DATA:0]          w_in;
    logic [WIDTH_DATA:0]          w_e0;
    logic [WIDTH_DATA:0]          w_e1;

`ifdef LD_BACKEND_BOUND_CHK_EN
    logic                         r_err;
    logic [WIDTH_ADDR:0]          w_sum;
    assign w_sum      = {1'b0, r_addr} + {1'b0, r_stride};
    assign w_addr_nxt = w_sum[WIDTH_ADDR-1:0];
    assign w_ovf      = w_sum[WIDTH_ADDR];
`else
    assign w_addr_nxt = r_addr + r_stride;
    assign w_ovf      = 1'b0;
`endif

    assign w_last = (r_rem == (WIDTH_ADDR+1)'(1)) | w_ovf;

    // Word arriving from CRAM this cycle is presented directly when the buffer is empty.
    assign O_Valid = (r_cnt != 2'd0) | r_arr;
    assign O_Data  = (r_cnt != 2'd0) ? r_buf[0][WIDTH_DATA-1:0] : (r_arr ? I_Rd_Data : '0);
    assign O_Last  = (r_cnt != 2'd0) ? r_buf[0][WIDTH_DATA] : r_arr_last;
    assign w_pop   = O_Valid & ~I_Stall;

    // Occupancy = buffered + arriving + requested; a new issue must keep it within 2.
    assign w_occ    = {1'b0, r_cnt} + {2'b00, r_arr} + {2'b00, O_Rd_Req};
    assign w_credit = (w_occ < 3'd2) | (w_pop & (w_occ == 3'd2));

    assign w_in = {r_arr_last, I_Rd_Data};
    assign w_e0 = (r_cnt != 2'd0) ? r_buf[0] : w_in;
    assign w_e1 = (r_cnt == 2'd2) ? r_buf[1] : w_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_arr      <= 1'b0;
            r_arr_last <= 1'b0;
            r_cnt      <= 2'd0;
            r_buf      <= '0;
        end else begin
            r_arr      <= O_Rd_Req;
            r_arr_last <= O_Rd_Req & r_req_last;
            r_cnt      <= r_cnt + {1'b0, r_arr} - {1'b0, w_pop};
            if (w_pop) begin
                r_buf[0] <= w_e1;
                r_buf[1] <= w_in;
            end else begin
                r_buf[0] <= w_e0;
                r_buf[1] <= w_e1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_rem       <= '0;
            r_indirect  <= 1'b0;
            r_req_last  <= 1'b0;
            O_Rd_Req    <= 1'b0;
            O_Rd_Addr   <= '0;
            O_Term_Load <= 1'b0;
            O_Ack       <= 1'b0;
            O_Error     <= 1'b0;
            O_Busy      <= 1'b0;
`ifdef LD_BACKEND_BOUND_CHK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            O_Rd_Req    <= 1'b0;
            O_Term_Load <= 1'b0;
            O_Ack       <= 1'b0;
            O_Error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (I_Start_Load) begin
                        r_addr     <= I_Base;
                        r_stride   <= I_Stride;
                        r_rem      <= I_Length;
                        r_indirect <= I_Indirect;
                        O_Busy     <= 1'b1;
`ifdef LD_BACKEND_BOUND_CHK_EN
                        r_err      <= 1'b0;
`endif
                        // Zero length passes through an already-empty DRAIN so DONE lands one cycle later.
                        r_state    <= (I_Length == '0) ? S_DRAIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_credit) begin
                        O_Rd_Req   <= 1'b1;
                        O_Rd_Addr  <= r_addr;
                        r_addr     <= w_addr_nxt;
                        r_rem      <= r_rem - (WIDTH_ADDR+1)'(1);
                        r_req_last <= w_last;
`ifdef LD_BACKEND_BOUND_CHK_EN
                        r_err      <= w_ovf & (r_rem != (WIDTH_ADDR+1)'(1));
`endif
                        if (w_last)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_cnt == 2'd0) && !r_arr && !O_Rd_Req) begin
                        r_state     <= S_DONE;
                        O_Term_Load <= 1'b1;
                        O_Ack       <= r_indirect;
`ifdef LD_BACKEND_BOUND_CHK_EN
                        O_Error     <= r_err;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    O_Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ld_ctrl_backend.sv
// Bench for ld_ctrl_backend: CRAM model, address/data scoreboard built from the load parameters, timing pins.
module tb_ld_ctrl_backend;
    localparam int WA = 10;
    localparam int WD = 32;
`ifdef LD_BACKEND_BOUND_CHK_EN
    localparam bit BND = 1'b1;
`else
    localparam bit BND = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          I_Start_Load = 1'b0;
    logic          I_Indirect = 1'b0;
    logic [WA:0]   I_Length = '0;
    logic [WA-1:0] I_Stride = '0;
    logic [WA-1:0] I_Base = '0;
    logic          I_Stall = 1'b0;
    logic [WD-1:0] I_Rd_Data = '0;
    logic          O_Rd_Req, O_Valid, O_Last, O_Term_Load, O_Ack, O_Error, O_Busy;
    logic [WA-1:0] O_Rd_Addr;
    logic [WD-1:0] O_Data;

    ld_ctrl_backend #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD)) dut (
        .clock(clock), .reset(reset), .I_Start_Load(I_Start_Load), .I_Indirect(I_Indirect),
        .I_Length(I_Length), .I_Stride(I_Stride), .I_Base(I_Base), .I_Stall(I_Stall),
        .I_Rd_Data(I_Rd_Data), .O_Rd_Req(O_Rd_Req), .O_Rd_Addr(O_Rd_Addr), .O_Valid(O_Valid),
        .O_Data(O_Data), .O_Last(O_Last), .O_Term_Load(O_Term_Load), .O_Ack(O_Ack),
        .O_Error(O_Error), .O_Busy(O_Busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [WD-1:0] mem_word(input logic [WA-1:0] a);
        return 32'hDA7A_0000 + {22'd0, a};
    endfunction

    // Synchronous CRAM: data for a request seen in one cycle appears in the next.
    always @(posedge clock) I_Rd_Data <= O_Rd_Req ? mem_word(O_Rd_Addr) : '0;

    int n_checks = 0;
    int n_err = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [WA-1:0] exp_addr[$];
    logic [WD:0]   exp_word[$];
    int            exp_m;
    logic          exp_err;

    task automatic build_model(input int base, input int stride, input int len);
        int a;
        logic [WD:0] w;
        exp_addr.delete();
        exp_word.delete();
        exp_m = 0;
        for (int k = 0; k < len; k++) begin
            a = base + k * stride;
            if (BND && a > (1 << WA) - 1) break;
            exp_addr.push_back(WA'(a % (1 << WA)));
            exp_word.push_back({1'b0, mem_word(WA'(a % (1 << WA)))});
            exp_m++;
        end
        if (exp_m > 0) begin
            w = exp_word.pop_back();
            w[WD] = 1'b1;
            exp_word.push_back(w);
        end
        exp_err = (exp_m < len);
    endtask

    logic chk_en = 1'b0;
    int t0 = 0;
    int crel;
    int n_req, n_pop, n_term, first_req, last_req, first_valid, last_valid, last_cyc, term_cyc, busy_low;
    logic ack_v, err_v, hold_pending;
    logic [WD-1:0] held;

    task automatic clear_track();
        n_req = 0; n_pop = 0; n_term = 0; first_req = -1; last_req = -1; first_valid = -1;
        last_valid = -1; last_cyc = -1; term_cyc = -1; busy_low = -1;
        ack_v = 1'b0; err_v = 1'b0; hold_pending = 1'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            crel = cyc - t0;
            if (O_Rd_Req) begin
                n_req++;
                if (first_req < 0) first_req = crel;
                last_req = crel;
                if (exp_addr.size() == 0) chk("extra_read", {54'd0, O_Rd_Addr}, 64'hFFFF);
                else chk("rd_addr", {54'd0, O_Rd_Addr}, {54'd0, exp_addr.pop_front()});
            end
            if (hold_pending) chk("stall_hold", {O_Valid, O_Data}, {1'b1, held});
            hold_pending = O_Valid && I_Stall;
            held = O_Data;
            if (O_Valid) begin
                if (first_valid < 0) first_valid = crel;
                last_valid = crel;
            end
            if (O_Valid && !I_Stall) begin
                n_pop++;
                if (O_Last) last_cyc = crel;
                if (exp_word.size() == 0) chk("extra_word", {O_Last, O_Data}, 64'hFFFF_FFFF_FFFF);
                else chk("word", {O_Last, O_Data}, exp_word.pop_front());
            end
            chk("outstanding_le2", (n_req - n_pop) <= 2, 1);
            if (O_Term_Load) begin
                n_term++;
                term_cyc = crel;
                ack_v = O_Ack;
                err_v = O_Error;
            end else if (O_Ack || O_Error) begin
                chk("stray_pulse", {O_Ack, O_Error}, 2'b00);
            end
            if (term_cyc >= 0 && !O_Busy && busy_low < 0) busy_low = crel;
        end
    end

    task automatic start_load(input int base, input int stride, input int len, input logic ind);
        @(posedge clock); #1;
        I_Start_Load = 1'b1; I_Base = WA'(base); I_Stride = WA'(stride);
        I_Length = (WA+1)'(len); I_Indirect = ind;
        @(posedge clock); #1;
        t0 = cyc;
        chk_en = 1'b1;
        // Scramble the parameter inputs: only the captured values may matter.
        I_Start_Load = 1'b0; I_Base = 10'h2AA; I_Stride = 10'h155; I_Length = 11'd9; I_Indirect = ~ind;
    endtask

    task automatic run(input int base, input int stride, input int len, input logic ind,
                       input int st_lo, input int st_hi, input int rs_cyc);
        int rel;
        build_model(base, stride, len);
        clear_track();
        start_load(base, stride, len, ind);
        for (int i = 0; i < 200; i++) begin
            rel = cyc - t0;
            I_Stall = (rel >= st_lo) && (rel <= st_hi);
            I_Start_Load = (rel == rs_cyc);
            if (rel == rs_cyc) begin
                I_Base = 10'h300; I_Length = 11'd3; I_Stride = 10'h7;
            end
            if (busy_low >= 0) break;
            @(posedge clock); #1;
        end
        chk_en = 1'b0; I_Stall = 1'b0; I_Start_Load = 1'b0;
        chk("done_in_budget", busy_low >= 0, 1);
        chk("reads_all_issued", exp_addr.size(), 0);
        chk("words_all_popped", exp_word.size(), 0);
        chk("term_count", n_term, 1);
        chk("ack", ack_v, ind);
        chk("error", err_v, exp_err);
        if (st_lo < 0 && exp_m > 0) begin
            chk("nostall_term_cyc", term_cyc, exp_m + 3);
            chk("nostall_first_valid", first_valid, 2);
            chk("nostall_last_word_cyc", last_cyc, exp_m + 1);
            chk("nostall_busy_low", busy_low, exp_m + 4);
        end
    endtask

    initial begin
        clear_track();
        repeat (3) @(negedge clock);
        chk("reset_outputs", {O_Rd_Req, O_Rd_Addr, O_Valid, O_Data, O_Last, O_Term_Load, O_Ack, O_Error, O_Busy}, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_outputs", {O_Rd_Req, O_Valid, O_Term_Load, O_Busy}, 4'b0000);

        // Basic 4-word load, no stall
        run(16, 1, 4, 1'b0, -1, -1, -1);
        chk("t1_first_req", first_req, 1);
        chk("t1_last_req", last_req, 4);
        chk("t1_n_req", n_req, 4);
        chk("t1_last_valid", last_valid, 5);
        chk("t1_last_word", last_cyc, 5);
        chk("t1_term", term_cyc, 7);
        chk("t1_busy_low", busy_low, 8);

        // Stall during cycles 3..6
        run(0, 3, 5, 1'b0, 3, 6, -1);
        chk("t2_n_pop", n_pop, 5);
        chk("t2_last_req", last_req, 9);
        chk("t2_last_word", last_cyc, 10);
        chk("t2_term", term_cyc, 12);

        // Zero length, indirect
        run(85, 1, 0, 1'b1, -1, -1, -1);
        chk("t3_n_req", n_req, 0);
        chk("t3_term", term_cyc, 1);
        chk("t3_ack", ack_v, 1);
        chk("t3_busy_low", busy_low, 2);

        // End of address space
        run(1022, 1, 4, 1'b0, -1, -1, -1);
`ifdef LD_BACKEND_BOUND_CHK_EN
        chk("t4_n_req", n_req, 2);
        chk("t4_last_word", last_cyc, 3);
        chk("t4_term", term_cyc, 5);
        chk("t4_err", err_v, 1);
`else
        chk("t4_n_req", n_req, 4);
        chk("t4_last_word", last_cyc, 5);
        chk("t4_term", term_cyc, 7);
        chk("t4_err", err_v, 0);
`endif

        // Start re-pulsed during LOAD
        run(32, 2, 5, 1'b0, -1, -1, 2);
        chk("t5_n_req", n_req, 5);
        chk("t5_term", term_cyc, 8);

        // Reset in the middle of a 6-word load, then restart elsewhere
        build_model(256, 2, 6);
        clear_track();
        start_load(256, 2, 6, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        chk_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {O_Rd_Req, O_Rd_Addr, O_Valid, O_Data, O_Last, O_Term_Load, O_Ack, O_Error, O_Busy}, 0);
        chk("mid_reset_reads_before", n_req, 2);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run(512, 1, 3, 1'b0, -1, -1, -1);
        chk("t6_first_req", first_req, 1);
        chk("t6_n_pop", n_pop, 3);
        chk("t6_term", term_cyc, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
